// File: rtl/execute_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : execute_multicycle
// Description : Execute stage with single-cycle ALU ops and iterative
//               signed multiply / unsigned divide into HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Dest,
    input  logic             Hold,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [4:0]       Dest_Out,
    output logic             Out_Valid,
    output logic             Busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_MULT = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8;
    localparam logic [3:0] OP_MFHI = 4'd9;
    localparam logic [3:0] OP_MFLO = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // product accumulator; remainder in low half
    logic [2*WIDTH-1:0]   mcand_q, mcand_d; // shifted multiplicand; divisor in low half
    logic [WIDTH-1:0]     work_q, work_d;   // multiplier bits / dividend-quotient
    logic [4:0]           dest_q, dest_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic [4:0]           dest_out_q, dest_out_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_alu;
    logic [SHW-1:0]       w_shamt;
    logic                 w_shift_ok;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_mul_addend;
    logic [2*WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH-1:0]     w_div_diff;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_rem;
    logic [WIDTH-1:0]     w_div_quo;

    assign Busy      = (state_q != S_IDLE);
    assign In_Ready  = !Busy && !Hold;
    assign w_accept  = In_Valid && In_Ready;
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Dest_Out  = dest_out_q;
    assign Out_Valid = out_valid_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

    // Single-cycle ALU; the whole A operand is the shift amount so any
    // amount of WIDTH or more yields zero.
    always_comb begin
        w_shamt    = A[SHW-1:0];
        w_shift_ok = (A < SHIFT_LIMIT);
        w_alu      = '0;
        case (Op)
            OP_AND:  w_alu = A & B;
            OP_OR:   w_alu = A | B;
            OP_ADD:  w_alu = A + B;
            OP_SUB:  w_alu = A - B;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  w_alu = w_shift_ok ? (B << w_shamt) : '0;
            OP_SRL:  w_alu = w_shift_ok ? (B >> w_shamt) : '0;
            OP_MFHI: w_alu = hi_q;
            OP_MFLO: w_alu = lo_q;
            default: w_alu = '0;
        endcase
    end

    // One iteration step: signed shift-add (top multiplier bit has negative
    // weight) and one restoring-division step.
    always_comb begin
        w_last       = (cnt_q == CW'(1));
        w_mul_addend = w_last ? ({(2*WIDTH){1'b0}} - mcand_q) : mcand_q;
        w_mul_acc    = work_q[0] ? (acc_q + w_mul_addend) : acc_q;
        w_div_shift  = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
        w_div_ge     = (w_div_shift >= {1'b0, mcand_q[WIDTH-1:0]});
        w_div_diff   = w_div_shift[WIDTH-1:0] - mcand_q[WIDTH-1:0];
        w_div_rem    = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
        w_div_quo    = {work_q[WIDTH-2:0], w_div_ge};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        work_d      = work_q;
        dest_d      = dest_q;
        result_d    = result_q;
        zero_d      = zero_q;
        dest_out_d  = dest_out_q;
        out_valid_d = Hold ? out_valid_q : 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (Op == OP_MULT) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        mcand_d = {{WIDTH{A[WIDTH-1]}}, A};
                        work_d  = B;
                        dest_d  = Dest;
                    end else if (Op == OP_DIVU) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, B};
                        work_d  = A;
                        dest_d  = Dest;
                    end else begin
                        result_d    = w_alu;
                        zero_d      = (w_alu == '0);
                        dest_out_d  = Dest;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d   = w_mul_acc;
                mcand_d = mcand_q << 1;
                work_d  = work_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (w_last) begin
                    state_d = S_DONE;
                    hi_d    = w_mul_acc[2*WIDTH-1:WIDTH];
                    lo_d    = w_mul_acc[WIDTH-1:0];
                end
            end
            S_DIV: begin
                acc_d  = {{WIDTH{1'b0}}, w_div_rem};
                work_d = w_div_quo;
                cnt_d  = cnt_q - CW'(1);
                if (w_last) begin
                    state_d = S_DONE;
                    hi_d    = w_div_rem;
                    lo_d    = w_div_quo;
                end
            end
            S_DONE: begin
                if (!Hold) begin
                    result_d    = lo_q;
                    zero_d      = (lo_q == '0);
                    dest_out_d  = dest_q;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            work_q      <= '0;
            dest_q      <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            dest_out_q  <= '0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            work_q      <= work_d;
            dest_q      <= dest_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            dest_out_q  <= dest_out_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_multicycle
// Description : Self-checking bench for execute_multicycle (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op_i = 4'd0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic [4:0]   dest_i = 5'd0;
    logic         hold = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic [4:0]   dest_out;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    execute_multicycle #(.WIDTH(W)) dut (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(in_ready),
        .Op(op_i), .A(a_i), .B(b_i), .Dest(dest_i), .Hold(hold),
        .Result(result), .Zero(zero), .Dest_Out(dest_out), .Out_Valid(out_valid),
        .Busy(busy), .Hi(hi), .Lo(lo)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] model_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [W-1:0] h, input logic [W-1:0] l);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return (a >= 32) ? 32'd0 : (b << a);
            4'd6:    return (a >= 32) ? 32'd0 : (b >> a);
            4'd9:    return h;
            4'd10:   return l;
            default: return 32'd0;
        endcase
    endfunction

    // Returns {HI, LO} for MULT (signed 64-bit product) or DIVU.
    function automatic logic [63:0] model_mc(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        if (op == 4'd7) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    logic [W-1:0] m_result = '0, m_hi = '0, m_lo = '0;
    logic         m_zero = 1'b0, m_valid = 1'b0, m_pending = 1'b0;
    logic [4:0]   m_dest_out = '0, m_pdest = '0;
    logic [63:0]  m_hilo = '0;
    int           m_age = 0;

    // Model: multicycle results land in HI/LO W edges after accept and
    // complete on the first un-held edge after that.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_result <= '0; m_zero <= 1'b0; m_dest_out <= '0; m_valid <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_pending <= 1'b0; m_age <= 0;
        end else begin
            if (!hold) m_valid <= 1'b0;
            if (m_pending) begin
                m_age <= m_age + 1;
                if (m_age + 1 == W) begin
                    m_hi <= m_hilo[63:32];
                    m_lo <= m_hilo[31:0];
                end
                if (m_age + 1 >= W + 1 && !hold) begin
                    m_result   <= m_lo;
                    m_zero     <= (m_lo == 0);
                    m_dest_out <= m_pdest;
                    m_valid    <= 1'b1;
                    m_pending  <= 1'b0;
                end
            end else if (in_valid && !hold) begin
                if (op_i == 4'd7 || op_i == 4'd8) begin
                    m_pending <= 1'b1;
                    m_age     <= 0;
                    m_pdest   <= dest_i;
                    m_hilo    <= model_mc(op_i, a_i, b_i);
                end else begin
                    m_result   <= model_alu(op_i, a_i, b_i, m_hi, m_lo);
                    m_zero     <= (model_alu(op_i, a_i, b_i, m_hi, m_lo) == 0);
                    m_dest_out <= dest_i;
                    m_valid    <= 1'b1;
                end
            end
        end
    end

    // Compare DUT against model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("result",    result,    m_result);
            check("zero",      zero,      m_zero);
            check("dest_out",  dest_out,  m_dest_out);
            check("out_valid", out_valid, m_valid);
            check("busy",      busy,      m_pending);
            check("in_ready",  in_ready,  !m_pending && !hold);
            check("hi",        hi,        m_hi);
            check("lo",        lo,        m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("issue_timeout", 1, 0);
        in_valid = 1'b1; op_i = op; a_i = a; b_i = b; dest_i = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("busy_timeout", 1, 0);
    endtask

    logic [3:0]   t_op  [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd1, 4'd6, 4'd4, 4'd13};
    logic [W-1:0] t_a   [10] = '{32'h5, 32'h9, 32'hFFFFFFFF, 32'h4, 32'h40, 32'hF0F0F0F0,
                                 32'h0F, 32'h4, 32'h1, 32'h5};
    logic [W-1:0] t_b   [10] = '{32'hFFFFFFF9, 32'h9, 32'h1, 32'h1, 32'hDEADBEEF, 32'hFF00FF00,
                                 32'hF0, 32'h80000000, 32'hFFFFFFFF, 32'h5};
    logic [W-1:0] t_exp [10] = '{32'hFFFFFFFE, 32'h0, 32'h1, 32'h10, 32'h0, 32'hF000F000,
                                 32'hFF, 32'h08000000, 32'h0, 32'h0};

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",      busy,      0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result,    0);
        check("rst_hi",        hi,        0);
        check("rst_lo",        lo,        0);
        rst = 1'b0;
        started = 1'b1;

        // single-cycle ops
        for (int i = 0; i < 10; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 5'(i + 1));
            check("alu_result", result, t_exp[i]);
            check("alu_zero",   zero,   (t_exp[i] == 0));
            check("alu_valid",  out_valid, 1);
            check("alu_dest",   dest_out, 5'(i + 1));
        end
        @(posedge clk); #1;
        check("valid_clears", out_valid, 0);

        // signed multiply
        issue(4'd7, 32'hFFFFFFFD, 32'h5, 5'd7);
        wait_idle(n);
        check("mult_busy_edges", n, W + 1);
        check("mult_hi",     hi,     32'hFFFFFFFF);
        check("mult_lo",     lo,     32'hFFFFFFF1);
        check("mult_result", result, 32'hFFFFFFF1);
        check("mult_valid",  out_valid, 1);
        check("mult_dest",   dest_out, 5'd7);
        issue(4'd9, 32'h0, 32'h0, 5'd8);
        check("mfhi", result, 32'hFFFFFFFF);
        issue(4'd10, 32'h0, 32'h0, 5'd9);
        check("mflo", result, 32'hFFFFFFF1);

        // unsigned divide, with an ignored request pulse while busy
        issue(4'd8, 32'd100, 32'd7, 5'd10);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; op_i = 4'd2; a_i = 32'h11; b_i = 32'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle(n);
        check("divu_lo", lo, 32'h0000000E);
        check("divu_hi", hi, 32'h00000002);
        issue(4'd8, 32'd1234, 32'd0, 5'd11);
        wait_idle(n);
        check("div0_edges", n, W + 1);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'h000004D2);

        // hold across DONE
        issue(4'd7, 32'h7, 32'hFFFFFFFE, 5'd12);
        hold = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b1; op_i = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W - 8) @(posedge clk);
        #1;
        check("hold_busy",     busy,      1);
        check("hold_valid",    out_valid, 0);
        check("hold_in_ready", in_ready,  0);
        check("hold_lo",       lo,        32'hFFFFFFF2);
        hold = 1'b0;
        @(posedge clk); #1;
        check("hold_done_valid",  out_valid, 1);
        check("hold_done_result", result,    32'hFFFFFFF2);
        check("hold_done_busy",   busy,      0);

        // asynchronous reset mid-multiply
        issue(4'd7, 32'h12345, 32'h6789, 5'd13);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy",  busy,      0);
        check("arst_valid", out_valid, 0);
        check("arst_hi",    hi,        0);
        check("arst_lo",    lo,        0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(4'd2, 32'h3, 32'h4, 5'd14);
        check("post_rst_add",   result,    32'h7);
        check("post_rst_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
